// File: rtl/prefix_adder_pkg.sv
// Shared constants and elaboration helpers for the pipelined Kogge-Stone adder.
package prefix_adder_pkg;

  localparam logic [1:0] KGP_KILL = 2'b00;
  localparam logic [1:0] KGP_GEN  = 2'b11;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // One capture stage plus one register per LVLS_PER_STAGE prefix levels.
  function automatic int calc_nst(input int width, input int lvls);
    return (clog2(width) + lvls - 1) / lvls + 1;
  endfunction

endpackage

// File: rtl/kgp_combine_cell.sv
// Kogge-Stone combine operator: a resolved (kill/generate) upper span wins, otherwise the lower span.
module kgp_combine_cell
  import prefix_adder_pkg::*;
(
  input  logic [1:0] hi_i,
  input  logic [1:0] lo_i,
  output logic [1:0] kgp_o
);

  assign kgp_o = (hi_i == KGP_KILL || hi_i == KGP_GEN) ? hi_i : lo_i;

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready, global-stall flow control and a tag sideband.
// Define ADDER_OVF_EN to add the registered signed-overflow output out_ovf.
module pipelined_prefix_adder
  import prefix_adder_pkg::*;
#(
  parameter int WIDTH          = 64,
  parameter int LVLS_PER_STAGE = 2,
  parameter int TAG_W          = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic [TAG_W-1:0] out_tag
`ifdef ADDER_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int LOG = clog2(WIDTH);
  localparam int NST = calc_nst(WIDTH, LVLS_PER_STAGE);

  logic adv;
  logic [NST:0] vld_pipe;

  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[NST];

  always_ff @(posedge clk) begin
    if (rst)      vld_pipe <= '0;
    else if (adv) vld_pipe <= {vld_pipe[NST-1:0], in_valid};
  end

  // Stage 0: effective operand, propagate vector and KGP bits.
  logic [WIDTH-1:0]      b_eff, p_d;
  logic                  cin_eff;
  logic [WIDTH-1:0][1:0] kgp_d;

  always_comb begin
    b_eff   = in_sub ? ~in_b : in_b;
    cin_eff = in_sub | in_cin;
    p_d     = in_a ^ b_eff;
    for (int i = 0; i < WIDTH; i++) kgp_d[i] = {in_a[i], b_eff[i]};
    // Folding the carry seed into bit 0 leaves every span resolved after the last level.
    if (p_d[0]) kgp_d[0] = cin_eff ? KGP_GEN : KGP_KILL;
  end

  logic [WIDTH-1:0][1:0] kgp0_q;
  logic [WIDTH-1:0]      p_q   [NST];
  logic                  cin_q [NST];
  logic [TAG_W-1:0]      tag_q [NST];

  always_ff @(posedge clk) begin
    if (adv) begin
      kgp0_q   <= kgp_d;
      p_q[0]   <= p_d;
      cin_q[0] <= cin_eff;
      tag_q[0] <= in_tag;
      for (int s = 1; s < NST; s++) begin
        p_q[s]   <= p_q[s-1];
        cin_q[s] <= cin_q[s-1];
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  // Prefix tree: nd[k] is the KGP vector entering level k.
  logic [WIDTH-1:0][1:0] nd [LOG+1];
  assign nd[0] = kgp0_q;

  for (genvar lv = 0; lv < LOG; lv++) begin : g_lvl
    localparam int D = 1 << lv;
    logic [WIDTH-1:0][1:0] cmb;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i < D) begin : g_pass
        assign cmb[i] = nd[lv][i];
      end else begin : g_cell
        kgp_combine_cell u_cell (
          .hi_i  (nd[lv][i]),
          .lo_i  (nd[lv][i-D]),
          .kgp_o (cmb[i])
        );
      end
    end

    if (((lv + 1) % LVLS_PER_STAGE == 0) || (lv == LOG - 1)) begin : g_reg
      logic [WIDTH-1:0][1:0] cmb_q;
      always_ff @(posedge clk) begin
        if (adv) cmb_q <= cmb;
      end
      assign nd[lv+1] = cmb_q;
    end else begin : g_comb
      assign nd[lv+1] = cmb;
    end
  end

  // c[i] is the carry out of bit i.
  logic [WIDTH-1:0] c, sum_d;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) c[i] = (nd[LOG][i] == KGP_GEN);
    sum_d = p_q[NST-1] ^ {c[WIDTH-2:0], cin_q[NST-1]};
  end

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic [TAG_W-1:0] otag_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      otag_q <= '0;
    end else if (adv) begin
      sum_q  <= sum_d;
      cout_q <= c[WIDTH-1];
      otag_q <= tag_q[NST-1];
    end
  end

  assign out_sum  = sum_q;
  assign out_cout = cout_q;
  assign out_tag  = otag_q;

`ifdef ADDER_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst)      ovf_q <= 1'b0;
    else if (adv) ovf_q <= c[WIDTH-1] ^ c[WIDTH-2];
  end

  assign out_ovf = ovf_q;
`endif

endmodule
